adapter_axi_stream_2_ppfifo: RTL and testbench

Ingress adapter: accepts an AXI Stream (data + user + last) and writes it into the write side of a dual-buffer Ping Pong FIFO. It grabs whichever write buffer is ready, fills it up to its advertised size, then releases it to the reader. It sits directly upstream of the ping-pong FIFO that feeds the PPFIFO-to-AXI-Stream egress adapter. Single clock domain.

---
 rtl/adapter_axi_stream_2_ppfifo_pkg.sv | 27 ++
 rtl/adapter_axi_stream_2_ppfifo.sv | 122 ++++++++++++
 tb/tb_adapter_axi_stream_2_ppfifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/adapter_axi_stream_2_ppfifo_pkg.sv
// Shared types and constants for the AXI Stream to ping-pong FIFO ingress adapter.
// Holds the FSM encoding, PPFIFO size width and the write-buffer selection helper.
package adapter_axi_stream_2_ppfifo_pkg;

    localparam int PPFIFO_SIZE_W = 24;

    localparam logic [1:0] NO_BUF = 2'b00;
    localparam logic [1:0] BUF0   = 2'b01;
    localparam logic [1:0] BUF1   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Buffer 0 wins when both write buffers are ready.
    function automatic logic [1:0] buf_select(input logic [1:0] rdy);
        if (rdy[0]) begin
            return BUF0;
        end else if (rdy[1]) begin
            return BUF1;
        end
        return NO_BUF;
    endfunction

endpackage

// File: rtl/adapter_axi_stream_2_ppfifo.sv
// AXI Stream ingress into the write side of a dual-buffer ping-pong FIFO.
// Define AXIS2PPFIFO_TLAST_RELEASE_EN to close the current buffer early on tlast.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no buffer held; grab a ready buffer and reset the word count
// ST_FILL  | buffer active; accept beats while count < buffer size
// ST_FLUSH | last write strobe in flight; drop act, return to idle
module adapter_axi_stream_2_ppfifo
    import adapter_axi_stream_2_ppfifo_pkg::*;
#(
    parameter int DATA_WIDTH             = 32,
    parameter int STROBE_WIDTH           = DATA_WIDTH / 8,
    parameter int USER_COUNT             = 1,
    parameter int MAP_AXI_USER_TO_PPFIFO = 1
) (
    input  logic                           i_axi_clk,
    input  logic                           rst_n,

    input  logic [1:0]                     i_ppfifo_rdy,
    output logic [1:0]                     o_ppfifo_act,
    input  logic [PPFIFO_SIZE_W-1:0]       i_ppfifo_size,
    output logic                           o_ppfifo_stb,
    output logic [DATA_WIDTH+USER_COUNT-1:0] o_ppfifo_data,

    output logic                           o_axi_ready,
    input  logic                           i_axi_valid,
    input  logic [DATA_WIDTH-1:0]          i_axi_data,
    input  logic [STROBE_WIDTH-1:0]        i_axi_keep,
    input  logic [3:0]                     i_axi_user,
    input  logic                           i_axi_last,

    output logic [PPFIFO_SIZE_W-1:0]       o_buffer_count
);

    state_t                   state;
    state_t                   state_nxt;
    logic [PPFIFO_SIZE_W-1:0] count;
    logic                     grab;
    logic                     handshake;
    logic                     tlast_close;
    logic [USER_COUNT-1:0]    user_field;
    logic                     unused_inputs;

`ifdef AXIS2PPFIFO_TLAST_RELEASE_EN
    assign tlast_close = i_axi_last;
`else
    assign tlast_close = 1'b0;
`endif

    assign user_field = (MAP_AXI_USER_TO_PPFIFO != 0) ? i_axi_user[USER_COUNT-1:0] : '0;

    // tkeep is not interpreted: every beat is stored as a full word.
    assign unused_inputs = ^{i_axi_keep, i_axi_user, i_axi_last};

    assign o_buffer_count = count;

    always_ff @(posedge i_axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_axi_ready = 1'b0;
        handshake   = 1'b0;
        grab        = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((o_ppfifo_act == NO_BUF) && (i_ppfifo_rdy != 2'b00)) begin
                    grab      = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                o_axi_ready = (count < i_ppfifo_size);
                handshake   = i_axi_valid & o_axi_ready;
                if (handshake) begin
                    if (((count + 24'd1) == i_ppfifo_size) || tlast_close) begin
                        state_nxt = ST_FLUSH;
                    end
                end else if (!o_axi_ready) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The final strobe lands in ST_FLUSH while act is still high.
    always_ff @(posedge i_axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ppfifo_act  <= NO_BUF;
            o_ppfifo_stb  <= 1'b0;
            o_ppfifo_data <= '0;
            count         <= '0;
        end else begin
            o_ppfifo_stb <= 1'b0;
            if (grab) begin
                o_ppfifo_act <= buf_select(i_ppfifo_rdy);
                count        <= '0;
            end
            if (handshake) begin
                o_ppfifo_stb  <= 1'b1;
                o_ppfifo_data <= {user_field, i_axi_data};
                count         <= count + 24'd1;
            end
            if (state == ST_FLUSH) begin
                o_ppfifo_act <= NO_BUF;
            end
        end
    end

endmodule

// File: tb/tb_adapter_axi_stream_2_ppfifo.sv
// Randomized self-checking bench for adapter_axi_stream_2_ppfifo against a buffer-session model.
// Honours AXIS2PPFIFO_TLAST_RELEASE_EN the same way as the design build.
module tb_adapter_axi_stream_2_ppfifo;

`ifdef AXIS2PPFIFO_TLAST_RELEASE_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    logic        i_axi_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  i_ppfifo_rdy = 2'b00;
    logic [1:0]  o_ppfifo_act;
    logic [23:0] i_ppfifo_size = 24'd0;
    logic        o_ppfifo_stb;
    logic [32:0] o_ppfifo_data;
    logic        o_axi_ready;
    logic        i_axi_valid = 1'b0;
    logic [31:0] i_axi_data = 32'd0;
    logic [3:0]  i_axi_keep = 4'd0;
    logic [3:0]  i_axi_user = 4'd0;
    logic        i_axi_last = 1'b0;
    logic [23:0] o_buffer_count;

    int checks = 0;
    int failures = 0;

    always #5 i_axi_clk = ~i_axi_clk;

    adapter_axi_stream_2_ppfifo dut (
        .i_axi_clk      (i_axi_clk),
        .rst_n          (rst_n),
        .i_ppfifo_rdy   (i_ppfifo_rdy),
        .o_ppfifo_act   (o_ppfifo_act),
        .i_ppfifo_size  (i_ppfifo_size),
        .o_ppfifo_stb   (o_ppfifo_stb),
        .o_ppfifo_data  (o_ppfifo_data),
        .o_axi_ready    (o_axi_ready),
        .i_axi_valid    (i_axi_valid),
        .i_axi_data     (i_axi_data),
        .i_axi_keep     (i_axi_keep),
        .i_axi_user     (i_axi_user),
        .i_axi_last     (i_axi_last),
        .o_buffer_count (o_buffer_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lowest-numbered ready buffer is taken.
    function automatic logic [1:0] pick_buffer(input logic [1:0] rdy);
        if (rdy[0]) return 2'b01;
        if (rdy[1]) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step(input int vpct, input logic [1:0] rdy, input logic [23:0] size);
        @(posedge i_axi_clk);
        #2;
        i_axi_valid  = (int'($urandom_range(0, 99)) < vpct);
        i_axi_data   = $urandom;
        i_axi_user   = 4'($urandom);
        i_axi_keep   = 4'($urandom);
        i_axi_last   = ($urandom_range(0, 7) == 0);
        i_ppfifo_rdy = rdy;
        if (o_ppfifo_act == 2'b00) i_ppfifo_size = size;
    endtask

    // Session model: one buffer grab, fill to size (or tlast), one flush cycle, act low.
    initial begin
        logic [1:0]  p_act, p_rdy, exp_act;
        logic        p_hs, hs, exp_rdy;
        logic [32:0] p_word;
        int          s_acc, s_size, s_words, s_age;
        bit          s_closed, s_by_last;
        p_act = 2'b00; p_rdy = 2'b00; p_hs = 1'b0; p_word = '0;
        s_acc = 0; s_size = 0; s_words = 0; s_age = 0; s_closed = 0; s_by_last = 0;
        forever begin
            @(negedge i_axi_clk);
            if (!rst_n) begin
                p_act = 2'b00; p_rdy = 2'b00; p_hs = 1'b0; s_closed = 0;
                continue;
            end
            chk("stb_latency", 64'(o_ppfifo_stb), 64'(p_hs));
            if (p_hs) chk("stb_data", 64'(o_ppfifo_data), 64'(p_word));
            chk("stb_without_act", 64'(o_ppfifo_stb && (o_ppfifo_act == 2'b00)), 64'd0);
            if (s_closed) s_age++;
            if (p_act == 2'b00) exp_act = pick_buffer(p_rdy);
            else exp_act = (s_closed && s_age >= 2) ? 2'b00 : p_act;
            chk("act", 64'(o_ppfifo_act), 64'(exp_act));
            if (p_act == 2'b00 && exp_act != 2'b00) begin
                s_acc = 0; s_words = 0; s_size = int'(i_ppfifo_size);
                s_closed = 0; s_age = 0; s_by_last = 0;
            end
            if (o_ppfifo_stb) s_words++;
            if (p_act != 2'b00 && exp_act == 2'b00) begin
                chk("words_vs_accepted", 64'(s_words), 64'(s_acc));
                if (!s_by_last) chk("words_vs_size", 64'(s_acc), 64'(s_size));
            end
            hs = 1'b0;
            if (exp_act != 2'b00) begin
                exp_rdy = !s_closed && (s_acc < s_size);
                chk("ready", 64'(o_axi_ready), 64'(exp_rdy));
                chk("buffer_count", 64'(o_buffer_count), 64'(s_acc));
                hs = i_axi_valid && exp_rdy;
                if (hs) s_acc++;
                if (!s_closed && (s_acc >= s_size || (TLAST_EN && hs && i_axi_last))) begin
                    s_closed = 1; s_age = 0; s_by_last = (s_acc < s_size);
                end
            end else begin
                chk("ready_idle", 64'(o_axi_ready), 64'd0);
            end
            p_act = exp_act;
            p_rdy = i_ppfifo_rdy;
            p_hs = hs;
            p_word = {i_axi_user[0], i_axi_data};
        end
    end

    initial begin
        int n;
        int vpct;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_act", 64'(o_ppfifo_act), 64'd0);
        chk("rst_stb", 64'(o_ppfifo_stb), 64'd0);
        chk("rst_data", 64'(o_ppfifo_data), 64'd0);
        chk("rst_count", 64'(o_buffer_count), 64'd0);
        chk("rst_ready", 64'(o_axi_ready), 64'd0);
        @(posedge i_axi_clk);
        #2 rst_n = 1'b1;

        // Both ready, size 4, continuous beats.
        for (int i = 0; i < 12; i++) step(100, 2'b11, 24'd4);
        // Alternate buffers, size 8.
        for (int i = 0; i < 12; i++) step(100, 2'b01, 24'd8);
        for (int i = 0; i < 14; i++) step(100, 2'b10, 24'd8);
        // Valid gaps, size 3.
        for (int i = 0; i < 30; i++) step(50, 2'b11, 24'd3);
        // Zero-size buffers.
        for (int i = 0; i < 10; i++) step(100, 2'b11, 24'd0);

        vpct = 100;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) vpct = int'($urandom_range(30, 100));
            step(vpct, 2'($urandom), 24'($urandom_range(0, 9)));
        end

        // Reset in the middle of a fill.
        n = 0;
        while (o_ppfifo_act == 2'b00 && n < 20) begin
            step(100, 2'b01, 24'd20);
            n++;
        end
        chk("grab_timeout", 64'(n < 20), 64'd1);
        for (int i = 0; i < 3; i++) step(100, 2'b01, 24'd20);
        @(posedge i_axi_clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_act", 64'(o_ppfifo_act), 64'd0);
        chk("midrst_stb", 64'(o_ppfifo_stb), 64'd0);
        chk("midrst_ready", 64'(o_axi_ready), 64'd0);
        chk("midrst_count", 64'(o_buffer_count), 64'd0);
        @(posedge i_axi_clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(100, 2'b10, 24'd5);

        n = 0;
        while (o_ppfifo_act != 2'b00 && n < 200) begin
            step(100, 2'b00, 24'd1);
            n++;
        end
        chk("drain_timeout", 64'(n < 200), 64'd1);
        for (int i = 0; i < 4; i++) step(0, 2'b00, 24'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
